// File: rtl/seg7_scan_driver.sv
// Time-multiplexed BCD-to-7-segment driver: captures NUM_DIGITS BCD digits on a load strobe and
// scans them onto a shared segment bus with one-hot digit select, blanking, blink and polarity control.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    bcd_err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // XOR masks applied at the pins so reset values are polarity-adjusted as well
  localparam bit                    INV     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_INV = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{INV}};

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_ph;

  logic [3:0]              cur_digit;
  logic                    cur_upper_zero;
  logic                    zero_run;
  logic                    load_bad;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1110011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  always_comb begin
    load_bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digits_in[4*k +: 4] > 4'd9) load_bad = 1'b1;
    end
  end

  // Walk from the most significant digit down so zero_run tells whether digit k and everything above it is zero
  always_comb begin
    cur_digit      = 4'd0;
    cur_upper_zero = 1'b0;
    zero_run       = 1'b1;
    sel_nxt        = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (shadow[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        cur_digit      = shadow[4*k +: 4];
        cur_upper_zero = zero_run;
        sel_nxt[k]     = 1'b1;
      end
    end
    if (blank_lz && (idx != '0) && cur_upper_zero) begin
      seg_nxt = 7'b0000000;
    end else begin
      seg_nxt = encode(cur_digit);
    end
    if (blink_en && blink_ph) begin
      seg_nxt = 7'b0000000;
      sel_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      pre       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      bcd_err   <= 1'b0;
      seg_out   <= SEG_INV;
      dig_sel   <= SEL_INV;
    end else begin
      if (load) begin
        shadow <= digits_in;
        if (load_bad) bcd_err <= 1'b1;
      end

      if (pre == PRE_LAST) begin
        pre <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
      end

      seg_out <= seg_nxt ^ SEG_INV;
      dig_sel <= sel_nxt ^ SEL_INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a timing model feeds an expected-value queue every clock,
// checked against an active-high and an active-low instance, plus directed display checks.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1110011;
  localparam logic [6:0] SD = 7'b0000001;
  localparam logic [6:0] SO = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [11:0] digits_in;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg_out, seg_al;
  logic [2:0]  dig_sel, sel_al;
  logic        bcd_err, err_al;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] seg;
    logic [2:0] sel;
    logic       err;
  } exp_t;

  exp_t sbq[$];

  int          m_e;
  logic [11:0] m_shadow;
  logic        m_err;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_out(seg_out), .dig_sel(dig_sel), .bcd_err(bcd_err)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg_out(seg_al), .dig_sel(sel_al), .bcd_err(err_al)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return S0;
      4'd1: return S1;
      4'd2: return S2;
      4'd3: return S3;
      4'd4: return S4;
      4'd5: return S5;
      4'd6: return S6;
      4'd7: return S7;
      4'd8: return S8;
      4'd9: return S9;
      default: return SD;
    endcase
  endfunction

  function automatic logic any_bad(input logic [11:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
  endfunction

  // Expected pins derived from elapsed cycles since reset release rather than from counters
  always @(posedge clk) begin : model
    exp_t x;
    int   idx;
    logic ph;
    if (reset) begin
      x.seg = SO;
      x.sel = 3'b000;
      x.err = 1'b0;
      m_e      <= 0;
      m_shadow <= 12'h000;
      m_err    <= 1'b0;
    end else begin
      idx   = (m_e / 4) % 3;
      ph    = ((m_e / 24) % 2) == 1;
      x.seg = seg_of(m_shadow[idx*4 +: 4]);
      if (blank_lz && idx > 0 && (m_shadow >> (4*idx)) == 12'h000) x.seg = SO;
      x.sel = 3'(1 << idx);
      if (blink_en && ph) begin
        x.seg = SO;
        x.sel = 3'b000;
      end
      x.err = m_err || (load && any_bad(digits_in));
      m_e   <= m_e + 1;
      m_err <= x.err;
      if (load) m_shadow <= digits_in;
    end
    sbq.push_back(x);
  end

  always @(negedge clk) begin : scoreboard
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      total++;
      assert (seg_out === x.seg) else begin bad++; $error("[TB] FAIL sb_seg got=%b want=%b t=%0t", seg_out, x.seg, $time); end
      total++;
      assert (dig_sel === x.sel) else begin bad++; $error("[TB] FAIL sb_sel got=%b want=%b t=%0t", dig_sel, x.sel, $time); end
      total++;
      assert (bcd_err === x.err) else begin bad++; $error("[TB] FAIL sb_err got=%b want=%b t=%0t", bcd_err, x.err, $time); end
      total++;
      assert (seg_al === ~x.seg) else begin bad++; $error("[TB] FAIL sb_seg_al got=%b want=%b t=%0t", seg_al, ~x.seg, $time); end
      total++;
      assert (sel_al === ~x.sel) else begin bad++; $error("[TB] FAIL sb_sel_al got=%b want=%b t=%0t", sel_al, ~x.sel, $time); end
      total++;
      assert (err_al === x.err) else begin bad++; $error("[TB] FAIL sb_err_al got=%b want=%b t=%0t", err_al, x.err, $time); end
    end
  end

  task automatic applyStimulus(input logic ld, input logic [11:0] v);
    load      = ld;
    digits_in = v;
  endtask

  task automatic loadDigits(input logic [11:0] v);
    applyStimulus(1'b1, v);
    @(negedge clk);
    applyStimulus(1'b0, v);
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] s, input logic [2:0] d);
    total++;
    assert (seg_out === s) else begin bad++; $error("[TB] FAIL %s seg got=%b want=%b", tag, seg_out, s); end
    total++;
    assert (dig_sel === d) else begin bad++; $error("[TB] FAIL %s sel got=%b want=%b", tag, dig_sel, d); end
  endtask

  task automatic checkAl(input string tag, input logic [6:0] s, input logic [2:0] d);
    total++;
    assert (seg_al === s) else begin bad++; $error("[TB] FAIL %s seg_al got=%b want=%b", tag, seg_al, s); end
    total++;
    assert (sel_al === d) else begin bad++; $error("[TB] FAIL %s sel_al got=%b want=%b", tag, sel_al, d); end
  endtask

  task automatic checkErr(input string tag, input logic e);
    total++;
    assert (bcd_err === e) else begin bad++; $error("[TB] FAIL %s err got=%b want=%b", tag, bcd_err, e); end
  endtask

  task automatic waitSel(input logic [2:0] tgt);
    int n = 0;
    while (dig_sel !== tgt && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (dig_sel === tgt) else begin bad++; $error("[TB] FAIL wait_sel got=%b want=%b", dig_sel, tgt); end
  endtask

  // Leaves the bench on the first negedge at which digit 0 is displayed
  task automatic syncDigit0();
    waitSel(3'b100);
    waitSel(3'b001);
  endtask

  task automatic checkDigits(input string tag, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] s;
    syncDigit0();
    for (int i = 0; i < 12; i++) begin
      s = (i < 4) ? s0 : (i < 8) ? s1 : s2;
      checkOutput(tag, s, 3'(1 << (i / 4)));
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    applyStimulus(1'b0, 12'h000);
    repeat (3) @(negedge clk);
    checkOutput("reset", SO, 3'b000);
    checkAl("reset", 7'b1111111, 3'b111);
    checkErr("reset", 1'b0);
    reset = 1'b0;

    $display("[TB] plain scan");
    loadDigits(12'h125);
    checkDigits("scan_125", S5, S2, S1);

    $display("[TB] leading-zero blanking");
    blank_lz = 1'b1;
    loadDigits(12'h007);
    checkDigits("lz_007", S7, SO, SO);
    loadDigits(12'h107);
    checkDigits("lz_107", S7, S0, S1);
    loadDigits(12'h050);
    checkDigits("lz_050", S0, S5, SO);
    loadDigits(12'h000);
    checkDigits("lz_000", S0, SO, SO);
    blank_lz = 1'b0;

    $display("[TB] invalid codes");
    checkErr("err_pre", 1'b0);
    loadDigits(12'h0A3);
    checkDigits("bad_0A3", S3, SD, S0);
    checkErr("err_set", 1'b1);
    loadDigits(12'h9EF);
    checkDigits("bad_9EF", SD, SD, S9);
    loadDigits(12'h4CB);
    checkDigits("bad_4CB", SD, SD, S4);
    loadDigits(12'hD68);
    checkDigits("bad_D68", S8, S6, SD);
    loadDigits(12'h000);
    checkDigits("after_000", S0, S0, S0);
    checkErr("err_sticky", 1'b1);

    $display("[TB] blink");
    reset = 1'b1;
    blink_en = 1'b1;
    repeat (2) @(negedge clk);
    checkErr("err_reset", 1'b0);
    checkOutput("reset2", SO, 3'b000);
    checkAl("reset2", 7'b1111111, 3'b111);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((i / 24) % 2 == 0) checkOutput("blink_on", S0, 3'(1 << ((i / 4) % 3)));
      else checkOutput("blink_off", SO, 3'b000);
    end
    blink_en = 1'b0;

    $display("[TB] active-low pins");
    loadDigits(12'h008);
    syncDigit0();
    checkAl("al_eight", 7'b0000000, 3'b110);

    $display("[TB] load on index advance, reset mid-digit");
    syncDigit0();
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 12'h456);
    @(negedge clk);
    applyStimulus(1'b0, 12'h456);
    @(negedge clk);
    checkOutput("load_adv", S5, 3'b010);
    waitSel(3'b100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset", SO, 3'b000);
    checkAl("mid_reset", 7'b1111111, 3'b111);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("restart_d0", S0, 3'b001);
    end
    @(negedge clk);
    checkOutput("restart_d1", S0, 3'b010);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
